// File: rtl/flit_activity_monitor.sv
// Receive-side flit link monitor: counts flits per fixed-length packet, accumulates
// inter-flit Hamming distance and the idle gap before each packet, and reports one record per packet.
module flit_activity_monitor #(
  parameter int W       = 30,
  parameter int PAYLOAD = 20,
  parameter int TOG_W   = 16,
  parameter int GAP_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [7:0]       sum_flits,
  output logic [TOG_W-1:0] sum_toggles,
  output logic [GAP_W-1:0] sum_gap,
  output logic             sum_err,
  output logic [15:0]      pkt_count
);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  localparam logic [7:0]       LAST_CNT   = 8'(PAYLOAD - 1);
  localparam logic [GAP_W-1:0] IDLE_LIMIT = GAP_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               armed;
  logic [W-1:0]       prev_flit;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   idle_cnt;
  logic               accept;
  logic [TOG_W-1:0]   tog;

  function automatic logic [TOG_W-1:0] popcount(input logic [W-1:0] v);
    logic [TOG_W-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) n = n + TOG_W'(v[i]);
    return n;
  endfunction

  function automatic logic [GAP_W-1:0] sat_inc(input logic [GAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // armed holds in_ready low until the first edge after reset release
  assign in_ready  = armed && (state != REPORT);
  assign sum_valid = (state == REPORT);
  assign accept    = in_valid && in_ready;
  assign tog       = popcount(in_data ^ prev_flit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (PAYLOAD == 1) ? REPORT : RECV;
      RECV: begin
        if (accept) begin
          if (sum_flits == LAST_CNT) state_nxt = REPORT;
        end else if (idle_cnt == IDLE_LIMIT) begin
          state_nxt = REPORT;
        end
      end
      REPORT:  if (sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The record registers double as the running accumulators; they only have to be
  // stable while sum_valid is high, which holds because REPORT never updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      prev_flit   <= '0;
      gap_cnt     <= '0;
      idle_cnt    <= '0;
      sum_flits   <= '0;
      sum_toggles <= '0;
      sum_gap     <= '0;
      sum_err     <= 1'b0;
      pkt_count   <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) prev_flit <= in_data;
      case (state)
        IDLE: begin
          if (accept) begin
            sum_gap     <= gap_cnt;
            sum_flits   <= 8'd1;
            sum_toggles <= tog;
            sum_err     <= 1'b0;
            gap_cnt     <= '0;
            idle_cnt    <= '0;
          end else if (armed) begin
            gap_cnt <= sat_inc(gap_cnt);
          end
        end
        RECV: begin
          if (accept) begin
            sum_flits   <= sum_flits + 8'd1;
            sum_toggles <= sum_toggles + tog;
            idle_cnt    <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDLE_LIMIT) sum_err <= 1'b1;
          end
        end
        REPORT: begin
          // gap_cnt was zeroed at the first accept, so REPORT cycles start the next gap
          gap_cnt <= sat_inc(gap_cnt);
          if (sum_ready) pkt_count <= pkt_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_activity_monitor.sv
// Scoreboard bench for flit_activity_monitor: directed packets push hand-computed records,
// a negedge monitor pops and compares on every summary handshake.
module tb_flit_activity_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [29:0] in_data;
  logic        in_ready;
  logic        sum_valid;
  logic        sum_ready;
  logic [7:0]  sum_flits;
  logic [15:0] sum_toggles;
  logic [7:0]  sum_gap;
  logic        sum_err;
  logic [15:0] pkt_count;

  flit_activity_monitor #(.W(30), .PAYLOAD(20), .TOG_W(16), .GAP_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_flits(sum_flits),
    .sum_toggles(sum_toggles), .sum_gap(sum_gap), .sum_err(sum_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  flits;
    logic [15:0] tog;
    logic [7:0]  gap;
    logic        chk_gap;
    logic        err;
    logic [15:0] pkt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_pkt = 0;
  logic [29:0] seq [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic push(input logic [7:0] f, input logic [15:0] t, input logic [7:0] g,
                      input logic cg, input logic e);
    exp_t x;
    x.flits = f; x.tog = t; x.gap = g; x.chk_gap = cg; x.err = e; x.pkt = exp_pkt;
    sb.push_back(x);
    exp_pkt++;
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_flit(input logic [29:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_flit: in_ready still 0 after 100 cycles, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // in_data wiggles while in_valid is low; none of it may count as toggles
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 30'h2AAAAAAA;
    repeat (n) begin
      @(posedge clk); #1;
      in_data = ~in_data;
    end
  endtask

  task automatic send_pkt(input int nflits);
    for (int i = 1; i <= nflits; i++) send_flit(seq[i % 15]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_pkt  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && sum_valid && sum_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_summary: got flits=%0d toggles=%0d, required none", sum_flits, sum_toggles);
      end else begin
        mon_e = sb.pop_front();
        check("sum_flits", sum_flits, mon_e.flits);
        check("sum_toggles", sum_toggles, mon_e.tog);
        check("sum_err", sum_err, mon_e.err);
        check("pkt_count", pkt_count, mon_e.pkt);
        if (mon_e.chk_gap) check("sum_gap", sum_gap, mon_e.gap);
      end
    end
  end

  initial begin
    // thermometer: fill from the MSB 4 bits at a time, shift to the LSBs, then drain
    seq[0]  = 30'h00000000; seq[1]  = 30'h3C000000; seq[2]  = 30'h3FC00000;
    seq[3]  = 30'h3FFC0000; seq[4]  = 30'h3FFFC000; seq[5]  = 30'h3FFFFC00;
    seq[6]  = 30'h3FFFFFC0; seq[7]  = 30'h3FFFFFFC; seq[8]  = 30'h0FFFFFFF;
    seq[9]  = 30'h00FFFFFF; seq[10] = 30'h000FFFFF; seq[11] = 30'h0000FFFF;
    seq[12] = 30'h00000FFF; seq[13] = 30'h000000FF; seq[14] = 30'h0000000F;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sum_ready = 1'b1;
    #22;
    check("reset_in_ready", in_ready, 0);
    check("reset_sum_valid", sum_valid, 0);
    check("reset_sum_flits", sum_flits, 0);
    check("reset_sum_toggles", sum_toggles, 0);
    check("reset_sum_gap", sum_gap, 0);
    check("reset_sum_err", sum_err, 0);
    check("reset_pkt_count", pkt_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // 1: thermometer packet from prev_flit=0
    push(8'd20, 16'd80, 8'd0, 1'b0, 1'b0);
    send_pkt(20);

    // 2: 7-cycle gap, first flit sees 16 toggles against 0x3FFFFC00
    idle(7);
    push(8'd20, 16'd92, 8'd7, 1'b1, 1'b0);
    send_pkt(20);

    // 3: back-to-back short packet aborted by timeout, then a normal one with a 14-cycle stall
    push(8'd5, 16'd32, 8'd1, 1'b1, 1'b1);
    send_pkt(5);
    idle(15);
    push(8'd20, 16'd92, 8'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      send_flit(seq[i % 15]);
      if (i == 10) idle(14);
    end

    // 4: consumer stalls the report for 10 cycles while a flit waits
    push(8'd20, 16'd92, 8'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) sum_ready = 1'b0;
      send_flit(seq[i % 15]);
    end
    in_valid = 1'b1;
    in_data  = seq[1];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_sum_valid", sum_valid, 1);
      check("stall_sum_flits", sum_flits, 20);
      check("stall_sum_toggles", sum_toggles, 92);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk); #1;
    check("post_handshake_in_ready", in_ready, 1);
    check("post_handshake_sum_valid", sum_valid, 0);
    push(8'd20, 16'd92, 8'd0, 1'b0, 1'b0);
    send_pkt(20);
    idle(3);

    // 5: asynchronous reset at flit 9 of a packet
    send_pkt(9);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_in_ready", in_ready, 0);
    check("async_sum_valid", sum_valid, 0);
    check("async_sum_flits", sum_flits, 0);
    check("async_sum_toggles", sum_toggles, 0);
    check("async_sum_gap", sum_gap, 0);
    check("async_sum_err", sum_err, 0);
    check("async_pkt_count", pkt_count, 0);
    do_reset();
    push(8'd20, 16'd80, 8'd0, 1'b0, 1'b0);
    send_pkt(20);
    idle(3);

    // 6: all-ones flits from prev_flit=0 after a saturating idle gap
    do_reset();
    idle(300);
    push(8'd20, 16'd30, 8'd255, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) send_flit(30'h3FFFFFFF);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
    check("final_pkt_count", pkt_count, 1);
    check("final_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
